// File: rtl/hazard_sequencer_if.sv
// hazard_sequencer_if: pipeline hazard inputs and stage enable/flush controls
interface hazard_sequencer_if #(parameter int COUNT_W = 16);
  logic redirect_ex;
  logic memread_ex;
  logic [4:0] rd_ex;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic rs1_used;
  logic rs2_used;
  logic dmem_req;
  logic dmem_ready;
  logic pc_en;
  logic if_id_en;
  logic if_id_flush;
  logic id_ex_en;
  logic id_ex_flush;
  logic ex_mem_en;
  logic mem_wb_flush;
  logic [COUNT_W-1:0] stall_cnt;
  logic [COUNT_W-1:0] redirect_cnt;
  modport master (
    output redirect_ex, memread_ex, rd_ex, rs1_id, rs2_id, rs1_used, rs2_used, dmem_req, dmem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, stall_cnt, redirect_cnt
  );
  modport slave (
    input  redirect_ex, memread_ex, rd_ex, rs1_id, rs2_id, rs1_used, rs2_used, dmem_req, dmem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, stall_cnt, redirect_cnt
  );
endinterface

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall/flush controller combining redirects, load-use and data-memory waits
module hazard_sequencer #(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int COUNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_sequencer_if.slave hz
);
  typedef enum logic [1:0] {INIT, RUN, REDIR, MWAIT} state_t;
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic ret_redir, ret_redir_nx;
  logic [COUNT_W-1:0] stall_q, redir_q;
  logic mw, lu, lu_st, active, go, in_redir;
  assign mw = hz.dmem_req & ~hz.dmem_ready;
  assign lu = hz.memread_ex & (hz.rd_ex != 5'd0) &
              ((hz.rs1_used & (hz.rs1_id == hz.rd_ex)) | (hz.rs2_used & (hz.rs2_id == hz.rd_ex)));
  assign active = state != INIT;
  assign go = active & ~mw;
  // On the ready cycle MWAIT behaves exactly like the state it interrupted
  assign in_redir = (state == REDIR) | ((state == MWAIT) & ret_redir);
  assign lu_st = go & ~hz.redirect_ex & ~in_redir & lu;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt <= 3'd0;
      ret_redir <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ret_redir <= ret_redir_nx;
    end
  end
  always_comb begin
    state_nx = RUN;
    cnt_nx = cnt;
    ret_redir_nx = ret_redir;
    if (active && mw) begin
      state_nx = MWAIT;
      ret_redir_nx = in_redir;
    end else if (active && hz.redirect_ex) begin
      state_nx = (REDIRECT_BUBBLES == 0) ? RUN : REDIR;
      cnt_nx = 3'(REDIRECT_BUBBLES);
    end else if (in_redir) begin
      state_nx = (cnt == 3'd1) ? RUN : REDIR;
      cnt_nx = cnt - 3'd1;
    end
  end
  always_comb begin
    hz.pc_en = go & ~lu_st;
    hz.if_id_en = go & ~lu_st;
    hz.id_ex_en = go;
    hz.ex_mem_en = go;
    hz.if_id_flush = ~active | (go & (hz.redirect_ex | in_redir));
    hz.id_ex_flush = ~active | (go & hz.redirect_ex) | lu_st;
    hz.mem_wb_flush = ~active | mw;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      if (active && !(go && !lu_st) && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (go && hz.redirect_ex && !(&redir_q)) redir_q <= redir_q + 1'b1;
    end
  end
  assign hz.stall_cnt = stall_q;
  assign hz.redirect_cnt = redir_q;
endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Central stall/flush controller for the 5-stage RV32I pipeline on DE1-SoC. It combines the EX-stage redirect (taken branch or JAL/JALR) with load-use hazard detection and data-memory wait handshakes. It drives per-stage register enables and flushes through a small FSM, and inserts a configurable number of extra IF/ID bubbles after a redirect to cover synchronous instruction-memory latency. It also maintains saturating stall and redirect event counters for on-board debug.

Parameters:
REDIRECT_BUBBLES, 1, extra cycles IF/ID stays flushed after a redirect; legal range 0..7.
COUNT_W, 16, width of the stall and redirect counters.

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
redirect_ex  input  1  branch taken or jump resolved in EX; high for the cycle the instruction is in ID/EX
memread_ex  input  1  instruction in EX is a load
rd_ex  input  5  destination register of the EX instruction
rs1_id  input  5  rs1 of the ID instruction
rs2_id  input  5  rs2 of the ID instruction
rs1_used  input  1  ID instruction reads rs1
rs2_used  input  1  ID instruction reads rs2
dmem_req  input  1  MEM stage is issuing a data-memory access
dmem_ready  input  1  data memory completes the access this cycle
pc_en  output  1  PC register update enable
if_id_en  output  1  IF/ID register enable
if_id_flush  output  1  IF/ID loads a NOP
id_ex_en  output  1  ID/EX register enable
id_ex_flush  output  1  ID/EX loads a bubble
ex_mem_en  output  1  EX/MEM register enable
mem_wb_flush  output  1  MEM/WB loads a bubble
stall_cnt  output  COUNT_W  saturating count of cycles with pc_en=0 while in RUN, REDIR or MWAIT
redirect_cnt  output  COUNT_W  saturating count of accepted redirects

Behaviour:
- States: INIT, RUN, REDIR, MWAIT. The state register and counters reset asynchronously: state=INIT, counters=0.
- Outputs are combinational from state and inputs. Default in every state: all enables 1, all flushes 0.
- INIT: all enables 0; if_id_flush, id_ex_flush and mem_wb_flush are 1. Always goes to RUN on the next clock, so the pipeline runs on the 2nd edge after reset release.
- Memory-wait condition mw = dmem_req & !dmem_ready. This condition has the highest priority in RUN and REDIR.
  - While mw: all enables 0, no flush except mem_wb_flush=1.
  - redirect_ex and load-use are ignored while mw. They stay valid because the stage registers hold.
  - On mw, the next state is MWAIT, and the return state (RUN, or REDIR with its remaining count) is saved.
- MWAIT: same outputs as mw while mw holds. When dmem_ready rises, that cycle evaluates as the saved state would (redirect and load-use are acted on), and the FSM returns to the saved state or its successor.
- Redirect (not mw): if_id_flush=1 and id_ex_flush=1; enables stay 1 so the PC loads the target. redirect_cnt increments.
  - REDIRECT_BUBBLES=0: stay in RUN.
  - Otherwise: go to REDIR with bubble counter = REDIRECT_BUBBLES.
- REDIR: if_id_flush=1; all enables 1; load-use detection suppressed, since ID holds a NOP. Counter decrements each non-mw cycle; the FSM returns to RUN after the cycle where the count reaches 1. A new redirect_ex in REDIR reloads the counter and increments redirect_cnt.
- Load-use, evaluated in RUN only:
  - lu = memread_ex & rd_ex!=0 & ((rs1_used & rs1_id==rd_ex) | (rs2_used & rs2_id==rd_ex)).
  - If lu and not redirect and not mw: pc_en=0, if_id_en=0, id_ex_flush=1. Lasts exactly 1 cycle, because the load then leaves EX.
  - Redirect beats load-use in the same cycle, because the ID instruction is wrong-path.
- stall_cnt increments on each clock where pc_en=0 in RUN, REDIR or MWAIT. Both counters saturate at 2^COUNT_W-1.
- Reset asserted mid-operation: immediate return to INIT outputs; counters cleared; any pending REDIR count or MWAIT return state is discarded.

Test Plan:
- Reset: rst_n low, then released. INIT outputs hold for 1 cycle (enables 0, flushes 1), then RUN with all enables 1 and counters 0.
- Load-use: memread_ex=1, rd_ex=5, rs2_id=5, rs2_used=1. For 1 cycle: pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1. The same stimulus with rd_ex=0 gives no stall.
- Redirect with REDIRECT_BUBBLES=1: redirect_ex pulse. Cycle 0: if_id_flush=1 and id_ex_flush=1. Cycle 1: if_id_flush=1 only. Cycle 2: back in RUN; redirect_cnt=1.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles. Enables 0 and mem_wb_flush=1 for 3 cycles; resume on the ready cycle; stall_cnt=3. Repeat with redirect_ex held high during the wait: the redirect is applied exactly once, on the ready cycle.
- Simultaneous redirect_ex and load-use: only the redirect response occurs (pc_en=1), with no load-use stall.
- Saturation and async reset: with COUNT_W=4, drive 20 load-use stalls; stall_cnt stays at 15. Asserting rst_n low mid-REDIR immediately forces INIT outputs and clears both counters.
